dma_ram_model: RTL and testbench

DMA_RAM_MODEL -- requirements
Module: dma_ram_model

---
 rtl/dma_ram_pkg.sv | 30 +++
 rtl/dma_ram_array.sv | 49 ++++
 rtl/dma_ram_model.sv | 165 ++++++++++++++++
 tb/tb_dma_ram_model.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_ram_pkg.sv
// Shared types and constants for the DMA RAM model (FSM states, error causes, word size).
// Optional build macro RAM_PRELOAD_EN adds the preload constants.
package dma_ram_pkg;

    localparam int unsigned DATA_W_DEF     = 32;
    localparam int unsigned BYTES_PER_WORD = DATA_W_DEF / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LAT  = 2'd1,
        ST_XFER = 2'd2
    } state_e;

    // One bit per rejection reason; any set bit rejects the command.
    typedef struct packed {
        logic dir_bad;
        logic misaligned;
        logic out_of_range;
        logic too_long;
    } err_cause_t;

`ifdef RAM_PRELOAD_EN
    localparam int unsigned PRELOAD_WORDS = 5;

    function automatic int unsigned preload_value(input int unsigned idx);
        return idx + 1;
    endfunction
`endif

endpackage

// File: rtl/dma_ram_array.sv
// Word storage with per-byte write enables and a combinational read port.
// With RAM_PRELOAD_EN defined, the low words are restored to 1..N on reset.
module dma_ram_array #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned AW     = 5
) (
    input  logic                clk,
`ifdef RAM_PRELOAD_EN
    input  logic                rst_n,
`endif
    input  logic                we_i,
    input  logic [AW-1:0]       waddr_i,
    input  logic [DATA_W/8-1:0] be_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [AW-1:0]       raddr_i,
    output logic [DATA_W-1:0]   rdata_o_c
);
    import dma_ram_pkg::*;

    localparam int unsigned BPW = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Only the preload words see reset; everything else keeps its contents.
`ifdef RAM_PRELOAD_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(PRELOAD_WORDS); i++) begin
                if (i < int'(DEPTH)) begin
                    mem_q[i] <= DATA_W'(preload_value(i));
                end
            end
        end else if (we_i) begin
`else
    always_ff @(posedge clk) begin
        if (we_i) begin
`endif
            for (int b = 0; b < int'(BPW); b++) begin
                if (be_i[b]) begin
                    mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o_c = mem_q[raddr_i];

endmodule

// File: rtl/dma_ram_model.sv
// Burst DMA target RAM: command sampling, latency wait, beat sequencing and error rejection.
// Build macro RAM_PRELOAD_EN preloads words 0..4 with 1..5 (see dma_ram_array).
module dma_ram_model
    import dma_ram_pkg::*;
#(
    parameter int unsigned DATA_W    = 8 * BYTES_PER_WORD,
    parameter int unsigned ADDR_W    = 64,
    parameter int unsigned DEPTH     = 32,
    parameter int unsigned LATENCY   = 2,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic                req,
    input  logic                write,
    input  logic                read,
    input  logic [ADDR_W-1:0]   address,
    input  logic [7:0]          burst_len,
    input  logic [DATA_W/8-1:0] byte_en,
    input  logic [DATA_W-1:0]   data_in,
    output logic                ack,
    output logic [DATA_W-1:0]   data_out,
    output logic                busy,
    output logic                error
);

    localparam int unsigned BPW      = DATA_W / 8;
    localparam int unsigned OFF      = $clog2(BPW);
    localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  LAT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    state_e            state_q, state_d;
    logic [3:0]        lat_q, lat_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [7:0]        len_q, len_d;
    logic [AW-1:0]     ptr_q, ptr_d;
    logic              write_q, write_d;
    logic              read_q, read_d;
    logic              ack_q, ack_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] dout_q, dout_d;

    err_cause_t        cause_c;
    logic [AW-1:0]     start_word_c;
    logic [AW-1:0]     ptr_next_c;
    logic [DATA_W-1:0] rd_data_c;
    logic              we_c;

    // Command validity checks, evaluated on the live request fields.
    always_comb begin
        cause_c              = '0;
        cause_c.dir_bad      = (read == write);
        cause_c.misaligned   = (address & ADDR_W'(BPW - 1)) != '0;
        cause_c.out_of_range = (address >> OFF) >= ADDR_W'(DEPTH);
        cause_c.too_long     = (9'(burst_len) + 9'd1) > 9'(MAX_BURST);
    end

    assign start_word_c = AW'(address >> OFF);
    assign ptr_next_c   = (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + AW'(1);

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        ptr_d   = ptr_q;
        write_d = write_q;
        read_d  = read_q;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // The error cycle itself never samples, so a held req is not rejected twice.
                if (req && !err_q) begin
                    if (|cause_c) begin
                        err_d = 1'b1;
                    end else begin
                        write_d = write;
                        read_d  = read;
                        len_d   = burst_len;
                        ptr_d   = start_word_c;
                        cnt_d   = '0;
                        lat_d   = LAT_INIT;
                        state_d = (LATENCY == 0) ? ST_XFER : ST_LAT;
                    end
                end
            end
            ST_LAT: begin
                if (lat_q == '0) begin
                    state_d = ST_XFER;
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            ST_XFER: begin
                if (cnt_q == len_q) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    ptr_d = ptr_next_c;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        ack_d  = (state_d == ST_XFER);
        busy_d = (state_d != ST_IDLE);
        // Read data is fetched one edge ahead so it lines up with the registered ack.
        dout_d = (state_d == ST_XFER && read_d) ? rd_data_c : dout_q;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            lat_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            ptr_q   <= '0;
            write_q <= 1'b0;
            read_q  <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            ptr_q   <= ptr_d;
            write_q <= write_d;
            read_q  <= read_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            dout_q  <= dout_d;
        end
    end

    assign we_c = (state_q == ST_XFER) && write_q;

    dma_ram_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_array (
        .clk       (CLK),
`ifdef RAM_PRELOAD_EN
        .rst_n     (RESET_N),
`endif
        .we_i      (we_c),
        .waddr_i   (ptr_q),
        .be_i      (byte_en),
        .wdata_i   (data_in),
        .raddr_i   (ptr_d),
        .rdata_o_c (rd_data_c)
    );

    assign ack      = ack_q;
    assign busy     = busy_q;
    assign error    = err_q;
    assign data_out = dout_q;

endmodule

// File: tb/tb_dma_ram_model.sv
// Self-checking bench for dma_ram_model: cycle-level expectations from a behavioural
// memory model, directed scenarios with literal pins, then randomized commands.
module tb_dma_ram_model;
    import dma_ram_pkg::*;

    localparam int unsigned DW    = 32;
    localparam int unsigned AWB   = 64;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned LAT   = 2;
    localparam int unsigned MAXB  = 16;
    localparam int unsigned BPW   = BYTES_PER_WORD;

    logic          CLK = 1'b0;
    logic          RESET_N = 1'b0;
    logic          req = 1'b0;
    logic          write = 1'b0;
    logic          read = 1'b0;
    logic [63:0]   address = '0;
    logic [7:0]    burst_len = '0;
    logic [3:0]    byte_en = '0;
    logic [31:0]   data_in = '0;
    logic          ack;
    logic [31:0]   data_out;
    logic          busy;
    logic          error;

    dma_ram_model #(
        .DATA_W    (DW),
        .ADDR_W    (AWB),
        .DEPTH     (DEPTH),
        .LATENCY   (LAT),
        .MAX_BURST (MAXB)
    ) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .req       (req),
        .write     (write),
        .read      (read),
        .address   (address),
        .burst_len (burst_len),
        .byte_en   (byte_en),
        .data_in   (data_in),
        .ack       (ack),
        .data_out  (data_out),
        .busy      (busy),
        .error     (error)
    );

    always #5 CLK = ~CLK;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model_mem [DEPTH];
    logic        exp_ack  = 1'b0;
    logic        exp_busy = 1'b0;
    logic        exp_err  = 1'b0;
    logic [31:0] exp_dout = '0;
    logic [31:0] beat_data [256];
    logic [3:0]  beat_be   [256];
    logic [31:0] rd_seen   [256];
    int          lat_seen;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Single compare point, half a cycle away from the active edge.
    always @(negedge CLK) begin
        check("ack", 64'(ack), 64'(exp_ack));
        check("busy", 64'(busy), 64'(exp_busy));
        check("error", 64'(error), 64'(exp_err));
        check("data_out", 64'(data_out), 64'(exp_dout));
    end

    task automatic model_reset();
`ifdef RAM_PRELOAD_EN
        for (int i = 0; i < 5; i++) model_mem[i] = 32'(i + 1);
`endif
    endtask

    task automatic idle(input int n);
        req = 1'b0;
        repeat (n) begin
            @(posedge CLK); #1;
        end
    endtask

    // Issue one command and step the expectations cycle by cycle from the timing rules.
    task automatic run_cmd(input logic wr, input logic rd, input logic [63:0] addr, input int len);
        bit ok;
        int w;
        int cyc;
        ok = (wr != rd) && (addr % BPW == 0) && (addr / BPW < 64'(DEPTH)) && (len + 1 <= int'(MAXB));
        req = 1'b1; write = wr; read = rd; address = addr; burst_len = 8'(len);
        data_in = $urandom; byte_en = 4'($urandom);
        lat_seen = -1;
        @(posedge CLK); #1;
        cyc = 1;
        if (!ok) begin
            exp_err = 1'b1;
            req = 1'b0;
            @(posedge CLK); #1;
            exp_err = 1'b0;
            return;
        end
        exp_busy = 1'b1;
        exp_ack  = 1'b0;
        for (int c = 0; c < int'(LAT); c++) begin
            write = 1'($urandom); read = 1'($urandom); address = {$urandom, $urandom};
            if (ack && lat_seen < 0) lat_seen = cyc;
            @(posedge CLK); #1;
            cyc++;
        end
        w = int'(addr / BPW);
        for (int k = 0; k <= len; k++) begin
            exp_ack = 1'b1;
            req = 1'b0;
            if (ack && lat_seen < 0) lat_seen = cyc;
            if (rd) begin
                exp_dout = model_mem[w];
                rd_seen[k] = data_out;
                data_in = $urandom; byte_en = 4'($urandom);
            end else begin
                data_in = beat_data[k]; byte_en = beat_be[k];
            end
            @(posedge CLK); #1;
            cyc++;
            if (wr) begin
                for (int b = 0; b < 4; b++)
                    if (beat_be[k][b]) model_mem[w][8*b +: 8] = beat_data[k][8*b +: 8];
            end
            w = (w + 1) % int'(DEPTH);
        end
        exp_ack  = 1'b0;
        exp_busy = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before timeout");
        $fatal(1, "bench timed out");
    end

    initial begin
        logic [31:0] d0, d1;
        for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = '0;
        model_reset();
        for (int i = 0; i < 256; i++) begin beat_data[i] = '0; beat_be[i] = 4'hF; end

        repeat (2) @(posedge CLK);
        #1;
        check("reset_ack", 64'(ack), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_data_out", 64'(data_out), 64'd0);
        RESET_N = 1'b1;

`ifdef RAM_PRELOAD_EN
        run_cmd(1'b0, 1'b1, 64'h0, 4);
        for (int k = 0; k < 5; k++) check("preload_word", 64'(rd_seen[k]), 64'(k + 1));
`else
        for (int k = 0; k < 5; k++) beat_data[k] = 32'(k + 1);
        run_cmd(1'b1, 1'b0, 64'h0, 4);
`endif
        for (int k = 0; k < 16; k++) begin beat_data[k] = '0; beat_be[k] = 4'hF; end
        run_cmd(1'b1, 1'b0, 64'(5 * BPW), 15);
        run_cmd(1'b1, 1'b0, 64'(21 * BPW), 10);

        run_cmd(1'b0, 1'b1, 64'h8, 0);
        check("single_read_data", 64'(rd_seen[0]), 64'd3);
        check("single_read_latency", 64'(lat_seen), 64'd3);

        for (int k = 0; k < 4; k++) begin beat_data[k] = 32'hA0 + 32'(k); beat_be[k] = 4'hF; end
        run_cmd(1'b1, 1'b0, 64'h10, 3);
        check("write_burst_latency", 64'(lat_seen), 64'd3);
        run_cmd(1'b0, 1'b1, 64'h10, 3);
        for (int k = 0; k < 4; k++) check("write_burst_readback", 64'(rd_seen[k]), 64'(32'hA0 + 32'(k)));

        beat_data[0] = 32'h1122_3344; beat_be[0] = 4'hF;
        run_cmd(1'b1, 1'b0, 64'h50, 0);
        beat_data[0] = 32'hDEAD_BEEF; beat_be[0] = 4'h3;
        run_cmd(1'b1, 1'b0, 64'h50, 0);
        run_cmd(1'b0, 1'b1, 64'h50, 0);
        check("byte_enable_dut", 64'(rd_seen[0]), 64'h1122_BEEF);
        check("byte_enable_model", 64'(model_mem[20]), 64'h1122_BEEF);

        for (int k = 0; k < 4; k++) begin beat_data[k] = 32'hC0 + 32'(k); beat_be[k] = 4'hF; end
        run_cmd(1'b1, 1'b0, 64'(30 * BPW), 3);
        check("wrap_model_w30", 64'(model_mem[30]), 64'hC0);
        check("wrap_model_w1", 64'(model_mem[1]), 64'hC3);
        run_cmd(1'b0, 1'b1, 64'(30 * BPW), 3);
        for (int k = 0; k < 4; k++) check("wrap_readback", 64'(rd_seen[k]), 64'(32'hC0 + 32'(k)));

        beat_data[0] = 32'hFFFF_FFFF; beat_be[0] = 4'hF;
        run_cmd(1'b1, 1'b0, 64'h2, 0);
        run_cmd(1'b1, 1'b1, 64'h0, 0);
        run_cmd(1'b1, 1'b0, 64'h0, 16);
        run_cmd(1'b0, 1'b1, 64'(DEPTH * BPW), 0);
        run_cmd(1'b1, 1'b0, 64'(DEPTH * BPW), 0);
        run_cmd(1'b0, 1'b1, 64'h0, 1);
        check("error_mem_w0", 64'(rd_seen[0]), 64'hC2);
        check("error_mem_w1", 64'(rd_seen[1]), 64'hC3);

        // Reset during the second beat of a four-beat write at word 12.
        d0 = 32'h5A5A_0001; d1 = 32'h5A5A_0002;
        req = 1'b1; write = 1'b1; read = 1'b0; address = 64'h30; burst_len = 8'd3; byte_en = 4'hF;
        @(posedge CLK); #1;
        exp_busy = 1'b1;
        repeat (LAT) begin @(posedge CLK); #1; end
        exp_ack = 1'b1; req = 1'b0; data_in = d0;
        @(posedge CLK); #1;
        model_mem[12] = d0;
        data_in = d1;
        #2;
        RESET_N = 1'b0;
        exp_ack = 1'b0; exp_busy = 1'b0; exp_dout = '0;
        model_reset();
        #1;
        check("reset_mid_ack", 64'(ack), 64'd0);
        check("reset_mid_busy", 64'(busy), 64'd0);
        @(posedge CLK); #1;
        RESET_N = 1'b1;
        run_cmd(1'b0, 1'b1, 64'h30, 3);
        check("after_reset_latency", 64'(lat_seen), 64'd3);
        check("after_reset_beat0", 64'(rd_seen[0]), 64'(d0));
        check("after_reset_beat1", 64'(rd_seen[1]), 64'd0);

        for (int n = 0; n < 250; n++) begin
            logic        wr, rd;
            logic [63:0] a;
            int          len, sel;
            sel = int'($urandom_range(0, 9));
            if (sel == 0) begin wr = 1'b1; rd = 1'b1; end
            else if (sel == 1) begin wr = 1'b0; rd = 1'b0; end
            else begin wr = 1'($urandom); rd = !wr; end
            a = 64'($urandom_range(0, DEPTH - 1)) * BPW;
            sel = int'($urandom_range(0, 19));
            if (sel == 0) a = a + 64'($urandom_range(1, BPW - 1));
            else if (sel == 1) a = 64'($urandom_range(DEPTH, 4 * DEPTH)) * BPW;
            else if (sel == 2) a = {$urandom | 32'h1, 32'h0};
            len = ($urandom_range(0, 19) == 0) ? int'($urandom_range(MAXB, 255))
                                               : int'($urandom_range(0, MAXB - 1));
            for (int k = 0; k < 256; k++) begin
                beat_data[k] = $urandom;
                beat_be[k]   = 4'($urandom);
            end
            run_cmd(wr, rd, a, len);
            idle(int'($urandom_range(0, 3)));
        end

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
